sram_march_bist: RTL and testbench
==================================

// Module: sram_march_bist
// PURPOSE
//   Hardware March C- engine for the user-area OpenRAM macro. It replaces firmware-driven
//   memtest loops with one parametrised sequencer driving the SRAM port directly.
//   Progress codes go out on an 8-bit bus routed to mprj_io[7:0]; step 0x0A per march
//   element, 0xFF = pass, 0xEE = fail. Failure address/data/element are captured for
//   readback over Wishbone.
// PARAMETERS
//   ADDR_W        8      SRAM address width
//   DATA_W        32     SRAM data width
//   READ_LAT      1      cycles from read issue (csb=0,web=1) to valid mem_dout; >=1
//   STOP_ON_FAIL  1      1: end test at first mismatch; 0: run to end, count errors
//   PROG_STEP     8'h0A  progress increment per march element
// PORTS
//   wb_clk_i     in   1       clock
//   wb_rst_i     in   1       asynchronous reset, active high
//   start        in   1       1-cycle pulse; sampled only when busy=0
//   addr_last    in   ADDR_W  highest address tested (range 0..addr_last); latched at start
//   bg           in   DATA_W  background pattern; latched at start
//   mem_csb      out  1       SRAM chip select, active low
//   mem_web      out  1       SRAM write enable, active low
//   mem_addr     out  ADDR_W  SRAM address
//   mem_din      out  DATA_W  SRAM write data
//   mem_dout     in   DATA_W  SRAM read data
//   busy         out  1       test running
//   done         out  1       high from end of test until next accepted start
//   pass         out  1       valid while done=1
//   progress     out  8       progress code
//   fail_addr    out  ADDR_W  address of first mismatch
//   fail_data    out  DATA_W  mem_dout value at first mismatch
//   fail_elem    out  3       march element index of first mismatch
//   err_count    out  16      mismatch count, saturates at 16'hFFFF
// BEHAVIOUR
//   Reset (async, immediate): mem_csb=1, mem_web=1, mem_addr=0, mem_din=0, busy=0,
//     done=0, pass=0, progress=0, fail_*=0, err_count=0; FSM returns to IDLE.
//     Reset mid-test aborts with no further SRAM access.
//   Elements (B=bg latched, ~B=inverse):
//     E0 up(wB)  E1 up(rB,w~B)  E2 up(r~B,wB)  E3 dn(rB,w~B)  E4 dn(r~B,wB)  E5 up(rB)
//     up = 0..addr_last; dn = addr_last..0.
//   FSM: IDLE -> RD -> WAIT(READ_LAT-1 cycles, csb=1) -> CMP -> ... -> FIN -> IDLE.
//     WR is used for E0.
//   Start: start with busy=0 at edge T0 sets busy=1, clears done, pass, fail_* and
//     err_count, and sets progress=0. The first SRAM access is driven in the cycle after T0.
//   Write-only element: 1 cycle per address.
//   Read-write element: RD cycle, then READ_LAT-1 idle cycles. The CMP cycle samples
//     mem_dout, compares, and issues the write in the same cycle (READ_LAT+1 cycles/addr).
//   E5: RD, wait, then CMP with no access.
//   progress = elem*PROG_STEP. It updates in the cycle the element's first access is driven.
//   Mismatch in CMP:
//     - Increment err_count, saturating.
//     - On the first mismatch only, capture fail_addr, fail_data and fail_elem.
//     - STOP_ON_FAIL=1: suppress that cycle's write and go to FIN.
//   FIN (1 cycle): busy=0, done=1, pass=(err_count==0), progress = pass ? 8'hFF : 8'hEE.
//   Boundaries:
//     - addr_last=0: single word, all elements run.
//     - addr_last=all-ones: no wrap; down count ends at 0 without underflow.
//   start while busy=1 is ignored. start and FIN in the same cycle: start is ignored.
//   mem_csb=1 in every cycle without an access (IDLE, WAIT, FIN).
// TESTING
//   1. ADDR_W=4, addr_last=15, bg=0, fault-free model, READ_LAT=1
//      -> progress 00,0A,14,1E,28,32,FF; done first high 177 cycles after T0; pass=1.
//   2. Same setup with addr 5 bit3 stuck-at-1, STOP_ON_FAIL=1
//      -> fail_addr=5, fail_data=0x08, fail_elem=1, err_count=1, pass=0, progress=EE,
//         no write to addr 5 in E1.
//   3. Same fault with STOP_ON_FAIL=0
//      -> err_count=3 (E1,E3,E5); first capture unchanged; done at 177 cycles; pass=0.
//   4. wb_rst_i asserted mid-E2
//      -> mem_csb=1 and busy=0 before the next edge, progress=0; rerun of test 1 passes.
//   5. addr_last=0, READ_LAT=2, bg=32'hA5A5A5A5
//      -> 16 access-phase cycles; mem_din alternates A5A5A5A5/5A5A5A5A; pass=1.
//   6. start pulsed during E3
//      -> ignored; err_count and fail_* not cleared; sequence completes normally.

Source files
------------

// File: rtl/sram_march_bist.sv
`default_nettype none
// ============================================================================
// Module      : sram_march_bist
// Description : March C- built-in self test sequencer for a single-port SRAM
//               macro. It runs six march elements over the address range
//               0..addr_last using a latched background pattern. It reports
//               progress on an 8-bit code bus and captures the first failing
//               address, data and element.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   wb_clk_i   in   1       clock
//   wb_rst_i   in   1       asynchronous reset, active high
//   start      in   1       start pulse, accepted only while busy=0
//   addr_last  in   ADDR_W  highest tested address, latched at start
//   bg         in   DATA_W  background pattern, latched at start
//   mem_csb    out  1       SRAM chip select, active low
//   mem_web    out  1       SRAM write enable, active low
//   mem_addr   out  ADDR_W  SRAM address
//   mem_din    out  DATA_W  SRAM write data
//   mem_dout   in   DATA_W  SRAM read data
//   busy       out  1       test running
//   done       out  1       test finished, held until next accepted start
//   pass       out  1       test result, valid while done=1
//   progress   out  8       element progress code, 8'hFF pass, 8'hEE fail
//   fail_addr  out  ADDR_W  address of first mismatch
//   fail_data  out  DATA_W  read data at first mismatch
//   fail_elem  out  3       march element of first mismatch
//   err_count  out  16      saturating mismatch count
// ============================================================================
module sram_march_bist #(
    parameter int         ADDR_W       = 8,
    parameter int         DATA_W       = 32,
    parameter int         READ_LAT     = 1,
    parameter int         STOP_ON_FAIL = 1,
    parameter logic [7:0] PROG_STEP    = 8'h0A
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_last,
    input  logic [DATA_W-1:0] bg,
    output logic              mem_csb,
    output logic              mem_web,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        progress,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [2:0]        fail_elem,
    output logic [15:0]       err_count
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_WR   = 3'd1;
    localparam logic [2:0] c_ST_RD   = 3'd2;
    localparam logic [2:0] c_ST_WAIT = 3'd3;
    localparam logic [2:0] c_ST_CMP  = 3'd4;
    localparam logic [2:0] c_ST_FIN  = 3'd5;

    localparam logic [2:0] c_ELEM_LAST = 3'd5;

    // WAIT lasts READ_LAT-1 cycles; the counter is loaded with READ_LAT-2
    // and the last WAIT cycle is the one where it reads zero.
    localparam int c_WCNT_W = (READ_LAT > 2) ? $clog2(READ_LAT - 1) : 1;
    localparam logic [c_WCNT_W-1:0] c_WAIT_INIT =
        c_WCNT_W'((READ_LAT > 1) ? (READ_LAT - 2) : 0);

    logic [2:0]          r_state;
    logic [2:0]          r_elem;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_last;
    logic [DATA_W-1:0]   r_bg;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [7:0]          r_progress;
    logic [ADDR_W-1:0]   r_fail_addr;
    logic [DATA_W-1:0]   r_fail_data;
    logic [2:0]          r_fail_elem;
    logic [15:0]         r_err_count;

    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_expect;
    logic                w_mismatch;
    logic                w_stop;
    logic                w_cmp_write;
    logic                w_write;
    logic                w_access;
    logic                w_elem_dn;
    logic                w_addr_end;
    logic [2:0]          w_next_elem;
    logic                w_next_dn;
    logic [15:0]         w_err_inc;

    // Odd elements read B and write ~B, even elements read ~B and write B,
    // so the expected read value is always the inverse of the write value.
    assign w_wdata    = r_elem[0] ? ~r_bg : r_bg;
    assign w_expect   = ~w_wdata;
    assign w_mismatch = (r_state == c_ST_CMP) && (mem_dout != w_expect);
    assign w_stop     = w_mismatch && (STOP_ON_FAIL != 0);

    // The CMP write depends on the compare result in the same cycle so a
    // failing cell is not overwritten when the test stops on it.
    assign w_cmp_write = (r_state == c_ST_CMP) && (r_elem != c_ELEM_LAST) && !w_stop;
    assign w_write     = (r_state == c_ST_WR) || w_cmp_write;
    assign w_access    = w_write || (r_state == c_ST_RD);

    assign mem_csb  = ~w_access;
    assign mem_web  = ~w_write;
    assign mem_addr = r_addr;
    assign mem_din  = w_write ? w_wdata : '0;

    assign w_elem_dn   = (r_elem == 3'd3) || (r_elem == 3'd4);
    assign w_addr_end  = w_elem_dn ? (r_addr == '0) : (r_addr == r_last);
    assign w_next_elem = r_elem + 3'd1;
    assign w_next_dn   = (w_next_elem == 3'd3) || (w_next_elem == 3'd4);
    assign w_err_inc   = (r_err_count == 16'hFFFF) ? r_err_count : r_err_count + 16'd1;

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign progress  = r_progress;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;
    assign fail_elem = r_fail_elem;
    assign err_count = r_err_count;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= c_ST_IDLE;
            r_elem      <= 3'd0;
            r_addr      <= '0;
            r_last      <= '0;
            r_bg        <= '0;
            r_wcnt      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_progress  <= 8'h00;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_fail_elem <= 3'd0;
            r_err_count <= 16'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_last      <= addr_last;
                        r_bg        <= bg;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_progress  <= 8'h00;
                        r_fail_addr <= '0;
                        r_fail_data <= '0;
                        r_fail_elem <= 3'd0;
                        r_err_count <= 16'd0;
                        r_elem      <= 3'd0;
                        r_addr      <= '0;
                        r_state     <= c_ST_WR;
                    end
                end

                c_ST_RD: begin
                    if (READ_LAT > 1) begin
                        r_wcnt  <= c_WAIT_INIT;
                        r_state <= c_ST_WAIT;
                    end else begin
                        r_state <= c_ST_CMP;
                    end
                end

                c_ST_WAIT: begin
                    if (r_wcnt == '0) begin
                        r_state <= c_ST_CMP;
                    end else begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end
                end

                // WR (element 0) and CMP both finish one address and step on.
                c_ST_WR, c_ST_CMP: begin
                    if (w_mismatch) begin
                        r_err_count <= w_err_inc;
                        if (r_err_count == 16'd0) begin
                            r_fail_addr <= r_addr;
                            r_fail_data <= mem_dout;
                            r_fail_elem <= r_elem;
                        end
                    end
                    if (w_stop) begin
                        r_state <= c_ST_FIN;
                    end else if (!w_addr_end) begin
                        r_addr  <= w_elem_dn ? (r_addr - 1'b1) : (r_addr + 1'b1);
                        r_state <= (r_elem == 3'd0) ? c_ST_WR : c_ST_RD;
                    end else if (r_elem == c_ELEM_LAST) begin
                        r_state <= c_ST_FIN;
                    end else begin
                        r_elem     <= w_next_elem;
                        r_addr     <= w_next_dn ? r_last : '0;
                        r_progress <= r_progress + PROG_STEP;
                        r_state    <= c_ST_RD;
                    end
                end

                c_ST_FIN: begin
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                    r_pass     <= (r_err_count == 16'd0);
                    r_progress <= (r_err_count == 16'd0) ? 8'hFF : 8'hEE;
                    r_state    <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_march_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_march_bist
// Description : Self-checking bench for sram_march_bist. Two instances share
//               one SRAM model: instance A (READ_LAT=1, stop on fail) and
//               instance B (READ_LAT=2, run to end). A reference model builds
//               the expected per-cycle access trace from the March C- element
//               table and the injected stuck-at fault.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_march_bist;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int MAXREC = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start_a, start_b;
    logic [AW-1:0] addr_last;
    logic [DW-1:0] bg;
    logic [DW-1:0] mem_dout;
    logic          sel;

    logic          a_csb, a_web, a_busy, a_done, a_pass;
    logic [AW-1:0] a_addr, a_faddr;
    logic [DW-1:0] a_din, a_fdata;
    logic [7:0]    a_prog;
    logic [2:0]    a_felem;
    logic [15:0]   a_err;

    logic          b_csb, b_web, b_busy, b_done, b_pass;
    logic [AW-1:0] b_addr, b_faddr;
    logic [DW-1:0] b_din, b_fdata;
    logic [7:0]    b_prog;
    logic [2:0]    b_felem;
    logic [15:0]   b_err;

    sram_march_bist #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .STOP_ON_FAIL(1), .PROG_STEP(8'h0A)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start_a), .addr_last(addr_last), .bg(bg),
        .mem_csb(a_csb), .mem_web(a_web), .mem_addr(a_addr), .mem_din(a_din), .mem_dout(mem_dout),
        .busy(a_busy), .done(a_done), .pass(a_pass), .progress(a_prog),
        .fail_addr(a_faddr), .fail_data(a_fdata), .fail_elem(a_felem), .err_count(a_err)
    );

    sram_march_bist #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(2), .STOP_ON_FAIL(0), .PROG_STEP(8'h0A)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start_b), .addr_last(addr_last), .bg(bg),
        .mem_csb(b_csb), .mem_web(b_web), .mem_addr(b_addr), .mem_din(b_din), .mem_dout(mem_dout),
        .busy(b_busy), .done(b_done), .pass(b_pass), .progress(b_prog),
        .fail_addr(b_faddr), .fail_data(b_fdata), .fail_elem(b_felem), .err_count(b_err)
    );

    // Outputs of the instance under test.
    logic          m_csb, m_web, m_busy, m_done, m_pass;
    logic [AW-1:0] m_addr, m_faddr;
    logic [DW-1:0] m_din, m_fdata;
    logic [7:0]    m_prog;
    logic [2:0]    m_felem;
    logic [15:0]   m_err;

    always_comb begin
        m_csb = sel ? b_csb : a_csb;   m_web = sel ? b_web : a_web;
        m_addr = sel ? b_addr : a_addr; m_din = sel ? b_din : a_din;
        m_busy = sel ? b_busy : a_busy; m_done = sel ? b_done : a_done;
        m_pass = sel ? b_pass : a_pass; m_prog = sel ? b_prog : a_prog;
        m_faddr = sel ? b_faddr : a_faddr; m_fdata = sel ? b_fdata : a_fdata;
        m_felem = sel ? b_felem : a_felem; m_err = sel ? b_err : a_err;
    end

    // ---------------- SRAM model with optional stuck-at cell ----------------
    logic          fault_en, fault_sv;
    logic [AW-1:0] fault_addr;
    logic [4:0]    fault_bit;
    logic [DW-1:0] mem [16];
    logic [DW-1:0] p1, p2;

    function automatic logic [DW-1:0] faulty(input int a, input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
        if (fault_en && a == int'(fault_addr)) r[fault_bit] = fault_sv;
        return r;
    endfunction

    always @(posedge clk) begin
        if (!m_csb && !m_web) mem[m_addr] <= m_din;
        p1 <= (!m_csb && m_web) ? faulty(int'(m_addr), mem[m_addr]) : 32'hDEADBEEF;
        p2 <= p1;
    end
    assign mem_dout = sel ? p2 : p1;

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // March C-: E0 up(wB) E1 up(rB,w~B) E2 up(r~B,wB) E3 dn(rB,w~B) E4 dn(r~B,wB) E5 up(rB)
    bit el_dn   [6] = '{0, 0, 0, 1, 1, 0};
    bit el_r    [6] = '{0, 1, 1, 1, 1, 1};
    bit el_rinv [6] = '{0, 0, 1, 0, 1, 0};
    bit el_w    [6] = '{1, 1, 1, 1, 1, 0};
    bit el_winv [6] = '{0, 1, 0, 1, 0, 0};

    bit            exp_acc  [MAXREC];
    bit            exp_we   [MAXREC];
    logic [AW-1:0] exp_addr [MAXREC];
    logic [DW-1:0] exp_din  [MAXREC];
    logic [7:0]    exp_prog [MAXREC];
    int            n_rec;
    int            exp_err;
    logic [AW-1:0] exp_fa;
    logic [DW-1:0] exp_fd;
    logic [2:0]    exp_fe;
    bit            exp_pass;

    function automatic void push(input bit acc, input bit we, input int a,
                                 input logic [DW-1:0] d, input logic [7:0] p);
        exp_acc[n_rec]  = acc;
        exp_we[n_rec]   = we;
        exp_addr[n_rec] = a[AW-1:0];
        exp_din[n_rec]  = d;
        exp_prog[n_rec] = p;
        n_rec++;
    endfunction

    task automatic build_model(input bit stop, input int lat);
        logic [DW-1:0] m [16];
        logic [DW-1:0] rv, ev, wv;
        logic [7:0]    prog;
        int            last, a;
        bit            halt;
        n_rec = 0; halt = 0; exp_err = 0; prog = 8'h00;
        exp_fa = '0; exp_fd = '0; exp_fe = '0;
        last = int'(addr_last);
        for (int e = 0; e < 6; e++) begin
            if (halt) break;
            prog = 8'(e * 10);
            for (int k = 0; k <= last; k++) begin
                a  = el_dn[e] ? (last - k) : k;
                wv = el_winv[e] ? ~bg : bg;
                if (!el_r[e]) begin
                    m[a] = wv;
                    push(1, 1, a, wv, prog);
                end else begin
                    push(1, 0, a, '0, prog);
                    for (int w = 1; w < lat; w++) push(0, 0, 0, '0, prog);
                    ev = el_rinv[e] ? ~bg : bg;
                    rv = faulty(a, m[a]);
                    if (rv !== ev) begin
                        if (exp_err == 0) begin
                            exp_fa = a[AW-1:0]; exp_fd = rv; exp_fe = 3'(e);
                        end
                        exp_err++;
                        if (stop) halt = 1;
                    end
                    if (el_w[e] && !halt) begin
                        m[a] = wv;
                        push(1, 1, a, wv, prog);
                    end else begin
                        push(0, 0, 0, '0, prog);
                    end
                end
                if (halt) break;
            end
        end
        push(0, 0, 0, '0, prog);   // FIN cycle
        exp_pass = (exp_err == 0);
    endtask

    // Runs one test on instance A (use_b=0) or B (use_b=1). A start pulse is
    // injected during trace cycle pulse_at (negative: none) and must be ignored.
    task automatic run(input string name, input bit use_b, input int pulse_at);
        sel = use_b;
        build_model(!use_b, use_b ? 2 : 1);
        @(negedge clk);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        for (int i = 0; i < n_rec; i++) begin
            @(negedge clk);
            start_a = (!use_b && i == pulse_at);
            start_b = ( use_b && i == pulse_at);
            check_val($sformatf("%s c%0d csb", name, i), m_csb, !exp_acc[i]);
            if (exp_acc[i]) begin
                check_val($sformatf("%s c%0d web", name, i), m_web, !exp_we[i]);
                check_val($sformatf("%s c%0d addr", name, i), m_addr, exp_addr[i]);
                if (exp_we[i]) check_val($sformatf("%s c%0d din", name, i), m_din, exp_din[i]);
            end
            check_val($sformatf("%s c%0d prog", name, i), m_prog, exp_prog[i]);
            check_val($sformatf("%s c%0d busy", name, i), m_busy, 1);
            check_val($sformatf("%s c%0d done", name, i), m_done, 0);
        end
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        check_val({name, " end done"}, m_done, 1);
        check_val({name, " end busy"}, m_busy, 0);
        check_val({name, " end csb"}, m_csb, 1);
        check_val({name, " end pass"}, m_pass, exp_pass);
        check_val({name, " end prog"}, m_prog, exp_pass ? 8'hFF : 8'hEE);
        check_val({name, " end err"}, m_err, 16'(exp_err));
        check_val({name, " end faddr"}, m_faddr, exp_fa);
        check_val({name, " end fdata"}, m_fdata, exp_fd);
        check_val({name, " end felem"}, m_felem, exp_fe);
        @(negedge clk);
        check_val({name, " hold done"}, m_done, 1);
        check_val({name, " hold busy"}, m_busy, 0);
        check_val({name, " hold csb"}, m_csb, 1);
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
        addr_last = '0; bg = '0;
        fault_en = 1'b0; fault_sv = 1'b1; fault_addr = '0; fault_bit = '0;
        repeat (3) @(negedge clk);
        check_val("rst a csb", a_csb, 1);      check_val("rst a web", a_web, 1);
        check_val("rst a addr", a_addr, 0);    check_val("rst a din", a_din, 0);
        check_val("rst a busy", a_busy, 0);    check_val("rst a done", a_done, 0);
        check_val("rst a pass", a_pass, 0);    check_val("rst a prog", a_prog, 0);
        check_val("rst a faddr", a_faddr, 0);  check_val("rst a fdata", a_fdata, 0);
        check_val("rst a felem", a_felem, 0);  check_val("rst a err", a_err, 0);
        check_val("rst b csb", b_csb, 1);      check_val("rst b busy", b_busy, 0);
        check_val("rst b done", b_done, 0);    check_val("rst b err", b_err, 0);
        rst = 1'b0;

        // Fault-free full range, 177 cycles from start to done.
        addr_last = 4'd15; bg = 32'h0;
        run("t1", 0, -1);
        check_val("t1 trace len", n_rec, 177);

        // Address 5 bit 3 stuck at 1, stop at first failure.
        fault_en = 1'b1; fault_addr = 4'd5; fault_bit = 5'd3; fault_sv = 1'b1;
        run("t2", 0, -1);
        check_val("t2 model err", exp_err, 1);

        // Same fault, run to end: E1, E3 and E5 miss.
        run("t3", 1, -1);
        check_val("t3 model err", exp_err, 3);

        // Start pulse during E3 (B: E3 begins at cycle 112) must be ignored.
        run("t6", 1, 120);
        // Start pulse during the FIN cycle must be ignored.
        run("t6fin", 0, n_rec - 1);

        // Single word, READ_LAT=2.
        fault_en = 1'b0; addr_last = 4'd0; bg = 32'hA5A5A5A5;
        run("t5", 1, -1);
        check_val("t5 trace len", n_rec, 17);

        // Reset in the middle of E2.
        sel = 1'b0; addr_last = 4'd15; bg = 32'h0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (53) @(negedge clk);
        check_val("t4 pre busy", m_busy, 1);
        #2 rst = 1'b1;
        #1;
        check_val("t4 csb", m_csb, 1);
        check_val("t4 busy", m_busy, 0);
        check_val("t4 prog", m_prog, 0);
        check_val("t4 done", m_done, 0);
        @(negedge clk); rst = 1'b0;
        run("t4rerun", 0, -1);

        // Randomised runs.
        for (int r = 0; r < 16; r++) begin
            addr_last  = 4'($urandom_range(0, 15));
            bg         = $urandom;
            fault_en   = ($urandom_range(0, 2) != 0);
            fault_addr = 4'($urandom_range(0, int'(addr_last)));
            fault_bit  = 5'($urandom_range(0, 31));
            fault_sv   = 1'($urandom_range(0, 1));
            run($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
